// File: rtl/crc32_wide.sv
// crc32_wide: multi-byte reflected CRC-32 (poly 0xEDB88320) engine.
// Folds up to DATA_BYTES bytes per beat into a running CRC. At frame end it
// emits the inverted FCS and a residue-match flag one cycle after the last beat.
module crc32_wide #(
  parameter int          DATA_BYTES  = 8,
  parameter logic [31:0] INITIAL_CRC = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE     = 32'hDEBB20E3
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [8*DATA_BYTES-1:0]           i_data,
  input  logic                              i_valid,
  input  logic                              i_start,
  input  logic                              i_last,
  input  logic [$clog2(DATA_BYTES+1)-1:0]   i_keep,
  output logic [31:0]                       o_crc,
  output logic                              o_crc_valid,
  output logic                              o_residue_ok
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  // One table entry: eight reflected shift/XOR steps on a single byte.
  function automatic logic [31:0] table_entry(input logic [7:0] idx);
    logic [31:0] c;
    c = {24'd0, idx};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc_table [256];
  logic [31:0] crc_q;
  logic [31:0] seed_p0;
  logic [31:0] fold_p0;
  int          nbytes_p0;

  // The table is a set of constants resolved at elaboration.
  for (genvar g = 0; g < 256; g++) begin : g_table
    assign crc_table[g] = table_entry(8'(g));
  end

  // Stage p0: seed select and byte-serial fold of the valid lanes, lane 0 first.
  always_comb begin
    seed_p0   = i_start ? INITIAL_CRC : crc_q;
    nbytes_p0 = DATA_BYTES;
    if (i_last) begin
      nbytes_p0 = (int'(i_keep) > DATA_BYTES) ? DATA_BYTES : int'(i_keep);
    end
    fold_p0 = seed_p0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (b < nbytes_p0) begin
        fold_p0 = (fold_p0 >> 8) ^ crc_table[fold_p0[7:0] ^ i_data[8*b +: 8]];
      end
    end
  end

  // Stage p1: running CRC update and frame-end result registers.
  // The last beat reseeds crc_q so the next frame needs no explicit start.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_q        <= INITIAL_CRC;
      o_crc        <= 32'd0;
      o_crc_valid  <= 1'b0;
      o_residue_ok <= 1'b0;
    end else begin
      o_crc_valid <= 1'b0;
      if (i_valid) begin
        if (i_last) begin
          crc_q        <= INITIAL_CRC;
          o_crc        <= fold_p0 ^ 32'hFFFFFFFF;
          o_residue_ok <= (fold_p0 == RESIDUE);
          o_crc_valid  <= 1'b1;
        end else begin
          crc_q <= fold_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_wide.sv
// Testbench for crc32_wide (DATA_BYTES = 8): known vectors, abort/reset
// sequences and random frames against a bitwise CRC-32 reference model.
module tb_crc32_wide;

  localparam int          DB  = 8;
  localparam logic [31:0] RES = 32'hDEBB20E3;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string       name;
    int          len;
    logic [7:0]  b [16];
    logic [31:0] crc;
    bit          res;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [63:0]   data;
  logic          valid;
  logic          start;
  logic          last;
  logic [3:0]    keep;
  logic [31:0]   crc;
  logic          crc_valid;
  logic          residue_ok;

  int checks = 0;
  int errors = 0;

  crc32_wide #(.DATA_BYTES(DB)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid),
    .i_start(start), .i_last(last), .i_keep(keep),
    .o_crc(crc), .o_crc_valid(crc_valid), .o_residue_ok(residue_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: classic bit-at-a-time reflected CRC-32, returns the register
  // value before final inversion.
  function automatic logic [31:0] ref_crc(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'd0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one beat, let it be accepted, then check the outputs it produced.
  task automatic drive_beat(input logic [63:0] d, input bit v, input bit s, input bit l,
                            input logic [3:0] k, input bit ep, input logic [31:0] ec,
                            input bit er);
    data = d; valid = v; start = s; last = l; keep = k;
    @(posedge clk);
    #1;
    chk("crc_valid", {31'd0, crc_valid}, {31'd0, ep});
    if (ep) begin
      chk("crc", crc, ec);
      chk("residue_ok", {31'd0, residue_ok}, {31'd0, er});
    end
  endtask

  task automatic idle_beat();
    drive_beat({$urandom, $urandom}, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom),
               1'b0, 32'd0, 1'b0);
  endtask

  // Split a frame into beats; unused lanes carry garbage so keep masking is exercised.
  task automatic send_frame(input bq_t d, input bit st, input int max_gap);
    int          n, nb, rem, gaps;
    logic [31:0] r;
    logic [63:0] w;
    logic [3:0]  k;
    bit          l;
    n  = d.size();
    nb = (n == 0) ? 1 : (n + DB - 1) / DB;
    r  = ref_crc(d);
    for (int bi = 0; bi < nb; bi++) begin
      gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gaps; g++) idle_beat();
      rem = n - bi * DB;
      l   = (bi == nb - 1);
      w   = {$urandom, $urandom};
      for (int j = 0; j < DB; j++) if (j < rem) w[8*j +: 8] = d[bi*DB + j];
      if (l) k = (rem == DB && $urandom_range(0, 1) == 1) ? 4'(DB + $urandom_range(0, 7)) : 4'(rem);
      else   k = 4'($urandom);
      drive_beat(w, 1'b1, st && (bi == 0), l, k, l, ~r, (r == RES));
    end
  endtask

  vec_t vecs [5];
  bq_t  q123;
  bq_t  q;
  bq_t  fq;

  initial begin
    vecs[0] = '{name: "check123", len: 9,
                b: '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,0,0,0,0,0,0,0},
                crc: 32'hCBF43926, res: 1'b0};
    vecs[1] = '{name: "residue", len: 13,
                b: '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h26,8'h39,8'hF4,8'hCB,0,0,0},
                crc: 32'h2144DF1C, res: 1'b1};
    vecs[2] = '{name: "empty", len: 0, b: '{default: 8'h00}, crc: 32'h00000000, res: 1'b0};
    vecs[3] = '{name: "empty2", len: 0, b: '{default: 8'h00}, crc: 32'h00000000, res: 1'b0};
    vecs[4] = '{name: "zero1", len: 1, b: '{default: 8'h00}, crc: 32'hD202EF8D, res: 1'b0};
    q123 = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39};

    rst_n = 1'b0; data = '0; valid = 1'b0; start = 1'b0; last = 1'b0; keep = '0;
    #1;
    chk("reset_crc", crc, 32'd0);
    chk("reset_valid", {31'd0, crc_valid}, 32'd0);
    chk("reset_res", {31'd0, residue_ok}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Known vectors; the table entries follow each other without idle cycles,
    // so the single-beat frames pulse on consecutive cycles.
    for (int v = 0; v < 5; v++) begin
      logic [63:0] w0, w1;
      int          n;
      n = vecs[v].len;
      w0 = {$urandom, $urandom};
      w1 = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) begin
        if (j < n)     w0[8*j +: 8] = vecs[v].b[j];
        if (j + 8 < n) w1[8*j +: 8] = vecs[v].b[j + 8];
      end
      if (n <= 8) begin
        drive_beat(w0, 1'b1, 1'b1, 1'b1, 4'(n), 1'b1, vecs[v].crc, vecs[v].res);
      end else begin
        drive_beat(w0, 1'b1, 1'b1, 1'b0, 4'($urandom), 1'b0, 32'd0, 1'b0);
        drive_beat(w1, 1'b1, 1'b0, 1'b1, 4'(n - 8), 1'b1, vecs[v].crc, vecs[v].res);
      end
    end

    // Back-to-back frames without start on the second, then with gaps inside.
    send_frame(q123, 1'b1, 0);
    send_frame(q123, 1'b0, 0);
    send_frame(q123, 1'b0, 3);

    // Abandon a partial frame with a fresh start; no pulse may appear for it.
    drive_beat({$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    send_frame(q123, 1'b1, 0);

    // Asynchronous reset mid-frame clears outputs before any clock edge.
    drive_beat({$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async_rst_crc", crc, 32'd0);
    chk("async_rst_valid", {31'd0, crc_valid}, 32'd0);
    chk("async_rst_res", {31'd0, residue_ok}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(q123, 1'b0, 0);

    // Random frames, some with their own FCS appended to hit the residue path.
    for (int f = 0; f < 24; f++) begin
      int          len;
      logic [31:0] r;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 1518);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        r = ~ref_crc(q);
        fq = q;
        for (int i = 0; i < 4; i++) fq.push_back(r[8*i +: 8]);
        q = fq;
      end
      send_frame(q, 1'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
